mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Multi-cycle memory sequencer sitting between the CPU control unit and the dual-bank `RAM` block. It accepts one load/store request at a time and checks address alignment and range. It drives the RAM's address, mode, write-data and write-enable lines for the required cycles. It waits out the synchronous-read latency, then latches read data into a memory data register (MDR) and returns a one-cycle acknowledge.

## Interface
Parameters:
- `ADDR_W`, 10: RAM halfword-address width; the byte address space is `2^(ADDR_W+1)` bytes.
- `READ_LAT`, 1: RAM read latency in cycles (1..3).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  1  request strobe; sampled only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_mode`  in  3  RAM mode code (`ram_ctrl` encoding, below).
- `req_addr`  in  32  CPU byte address.
- `req_wdata`  in  32  store data.
- `busy`  out  1  high in every state except IDLE.
- `ack`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `ack`; 1 = request rejected, no RAM access.
- `mdr`  out  32  last load result; held until the next successful load.
- `ram_addr`  out  ADDR_W  to `RAM.addr` (halfword index).
- `ram_ctrl`  out  3  to `RAM.RAMCtrl`.
- `ram_din`  out  32  to `RAM.din`.
- `ram_we`  out  1  to `RAM.we`.
- `ram_dout`  in  32  from `RAM.dout`.

## Operation
- Mode codes:
  - `000`: word, normal order.
  - `001`: word, swapped halves.
  - `100`/`101`: halfword zero-extend, byte-swapped/native.
  - `110`/`111`: halfword sign-extend, byte-swapped/native.
  - `010`/`011`: illegal.
- Request acceptance, in IDLE with `req`=1: register `req_we`, `req_mode` and `req_wdata`. Register `ram_addr = req_addr[ADDR_W:1]`.
- Fault check, in priority order; any hit takes the request to ERR:
  - `req_addr[0]`=1 (misaligned).
  - `req_addr[31:ADDR_W+1]` ≠ 0 (out of range).
  - Illegal mode.
- States:
  - IDLE: `req` clean goes to ISSUE; `req` faulty goes to ERR.
  - ISSUE: `ram_we` = registered `req_we` for exactly this cycle. Store goes to DONE. Load goes to WAIT with the latency counter loaded to `READ_LAT-1`.
  - WAIT: counter decrements each cycle. At 0, capture `mdr <= ram_dout` and go to DONE.
  - DONE: `ack`=1, `err`=0, then IDLE.
  - ERR: `ack`=1, `err`=1, no RAM write, `mdr` unchanged, then IDLE.
- `ram_addr`, `ram_ctrl` and `ram_din` hold their registered values from ISSUE through DONE. They also hold their values in IDLE (no glitching to the RAM).
- `req` in any state other than IDLE is ignored, not queued.
- Reset values: state IDLE; `ram_we`, `ack`, `err` and `busy` = 0; `mdr`, `ram_addr`, `ram_ctrl` and `ram_din` = 0.
- Reset mid-operation: at the next edge, `ram_we` drops and no `ack` is issued. An in-flight load does not update `mdr`.

## Timing
- Cycle 0: `req` sampled.
- Store: ISSUE at cycle 1 (`ram_we`=1); `ack` at cycle 2.
- Load: ISSUE at cycle 1; `mdr` valid and `ack` high at cycle `2+READ_LAT`. With `READ_LAT`=1, `ack` is at cycle 3.
- Error: `ack`+`err` at cycle 1.
- Back-to-back: a new `req` is accepted on the cycle after `ack` (IDLE). Minimum store-to-store spacing is 3 cycles.
- `busy` rises the cycle after acceptance and falls with the return to IDLE.

## Structure
- Shared package `mem_pkg` holds:
  - state enum: IDLE, ISSUE, WAIT, DONE, ERR;
  - mode constants: `MODE_WORD`, `MODE_WORD_SW`, `MODE_HU_SW`, `MODE_HU`, `MODE_HS_SW`, `MODE_HS`;
  - `mode_legal()` function.
- Single flat module, no sub-module. The parent instantiates `RAM` alongside it and wires the `ram_*` ports directly.

## Test plan
- Store then load:
  - Stimulus: store `0xDEADBEEF`, mode `000`, `req_addr 0x10`; then load from the same address.
  - Required: `ram_addr`=8, `ram_we` high exactly 1 cycle, `ack` at cycle 2; load `ack` at cycle 3 with `mdr`=`0xDEADBEEF`, `err`=0.
- Halfword sign-extend:
  - Stimulus: store `0x00008001`, mode `101`, addr `0x22`; load mode `111`.
  - Required: `mdr`=`0xFFFF8001`. Load mode `101` gives `mdr`=`0x00008001`.
- Faults:
  - `req_addr 0x13` → `ack`+`err` at cycle 1, `ram_we` never high, `mdr` unchanged.
  - `req_addr 0x800` (`ADDR_W`=10) → `err`.
  - Mode `010` → `err`.
- `req` while busy:
  - Stimulus: assert `req` continuously during a load.
  - Required: exactly one access; the second request is accepted only in the cycle after `ack`.
- Reset in WAIT:
  - Stimulus: assert `rst` in the WAIT cycle of a load.
  - Required: next cycle all outputs 0, no `ack`, `mdr`=0, `busy`=0.
- `READ_LAT`=3:
  - Required: load `ack` at cycle 5; `mdr` equals the RAM contents.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access sequencer: FSM states,
// RAM mode codes and the mode legality check.
package mem_pkg;

    typedef logic [2:0] mode_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE,
        ERR
    } state_t;

    localparam mode_t MODE_WORD    = 3'b000;
    localparam mode_t MODE_WORD_SW = 3'b001;
    localparam mode_t MODE_HU_SW   = 3'b100;
    localparam mode_t MODE_HU      = 3'b101;
    localparam mode_t MODE_HS_SW   = 3'b110;
    localparam mode_t MODE_HS      = 3'b111;

    // Codes 010 and 011 have no RAM meaning.
    function automatic logic mode_legal(mode_t m);
        return m[2:1] != 2'b01;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// CPU-side request/response bus of the memory access sequencer.
// The CPU control unit drives the request (master); the sequencer
// answers with busy/ack/err and the memory data register (slave).
interface mem_access_ctrl_if;
    import mem_pkg::*;

    logic        req;
    logic        req_we;
    mode_t       req_mode;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        ack;
    logic        err;
    logic [31:0] mdr;

    modport master (
        output req, req_we, req_mode, req_addr, req_wdata,
        input  busy, ack, err, mdr
    );

    modport slave (
        input  req, req_we, req_mode, req_addr, req_wdata,
        output busy, ack, err, mdr
    );

endinterface

// File: rtl/mem_access_ctrl.sv
// Multi-cycle load/store sequencer between the CPU control unit and the
// dual-bank RAM. One request at a time: alignment, range and mode are
// checked in IDLE, the RAM lines are driven from registers, the read
// latency is waited out and load data is captured into the MDR.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_ctrl_if.slave  cpu,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [2:0]        ram_ctrl,
    output logic [31:0]       ram_din,
    output logic              ram_we,
    input  logic [31:0]       ram_dout
);

    state_t            state_q;
    logic              we_q;
    logic [1:0]        lat_q;
    logic              busy_q;
    logic              ack_q;
    logic              err_q;
    logic [31:0]       mdr_q;
    logic [ADDR_W-1:0] ram_addr_q;
    mode_t             ram_ctrl_q;
    logic [31:0]       ram_din_q;
    logic              ram_we_q;

    logic misaligned;
    logic out_of_range;
    logic bad_mode;
    logic req_fault;

    assign misaligned   = cpu.req_addr[0];
    assign out_of_range = (cpu.req_addr >> (ADDR_W + 1)) != '0;
    assign bad_mode     = !mode_legal(cpu.req_mode);
    assign req_fault    = misaligned | out_of_range | bad_mode;

    // Sequencer FSM; every output is registered so the RAM lines never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            lat_q      <= '0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            mdr_q      <= '0;
            ram_addr_q <= '0;
            ram_ctrl_q <= '0;
            ram_din_q  <= '0;
            ram_we_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu.req) begin
                        busy_q <= 1'b1;
                        if (req_fault) begin
                            // Rejected requests leave the RAM lines untouched.
                            state_q <= ERR;
                            ack_q   <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q    <= ISSUE;
                            we_q       <= cpu.req_we;
                            ram_we_q   <= cpu.req_we;
                            ram_addr_q <= cpu.req_addr[ADDR_W:1];
                            ram_ctrl_q <= cpu.req_mode;
                            ram_din_q  <= cpu.req_wdata;
                        end
                    end
                end
                ISSUE: begin
                    ram_we_q <= 1'b0;
                    if (we_q) begin
                        state_q <= DONE;
                        ack_q   <= 1'b1;
                    end else begin
                        state_q <= WAIT;
                        lat_q   <= 2'(READ_LAT - 1);
                    end
                end
                WAIT: begin
                    if (lat_q == '0) begin
                        mdr_q   <= ram_dout;
                        state_q <= DONE;
                        ack_q   <= 1'b1;
                    end else begin
                        lat_q <= lat_q - 2'd1;
                    end
                end
                DONE, ERR: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cpu.busy = busy_q;
    assign cpu.ack  = ack_q;
    assign cpu.err  = err_q;
    assign cpu.mdr  = mdr_q;

    assign ram_addr = ram_addr_q;
    assign ram_ctrl = ram_ctrl_q;
    assign ram_din  = ram_din_q;
    assign ram_we   = ram_we_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: two instances (READ_LAT 1 and 3),
// each with a behavioural dual-bank halfword RAM, and a scoreboard of
// expected completions.
module tb_mem_access_ctrl;
    import mem_pkg::*;

    localparam int unsigned AW = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_access_ctrl_if if1 ();
    mem_access_ctrl_if if3 ();

    logic [AW-1:0] ram_addr1, ram_addr3;
    logic [2:0]    ram_ctrl1, ram_ctrl3;
    logic [31:0]   ram_din1, ram_din3;
    logic          ram_we1, ram_we3;
    logic [31:0]   ram_dout1, ram_dout3;

    mem_access_ctrl #(.ADDR_W(AW), .READ_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .cpu(if1),
        .ram_addr(ram_addr1), .ram_ctrl(ram_ctrl1), .ram_din(ram_din1),
        .ram_we(ram_we1), .ram_dout(ram_dout1)
    );

    mem_access_ctrl #(.ADDR_W(AW), .READ_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .cpu(if3),
        .ram_addr(ram_addr3), .ram_ctrl(ram_ctrl3), .ram_din(ram_din3),
        .ram_we(ram_we3), .ram_dout(ram_dout3)
    );

    // Behavioural RAM: halfword array, word = {mem[a+1], mem[a]} in normal order.
    logic [15:0] mem1 [0:(1<<AW)-1];
    logic [15:0] mem3 [0:(1<<AW)-1];
    logic [31:0] pipe1;
    logic [31:0] pipe3 [0:2];
    logic [AW-1:0] nxt1, nxt3;
    assign nxt1 = ram_addr1 + 1'b1;
    assign nxt3 = ram_addr3 + 1'b1;
    assign ram_dout1 = pipe1;
    assign ram_dout3 = pipe3[2];

    function automatic logic [31:0] rd_fmt(logic [2:0] m, logic [15:0] h0, logic [15:0] h1);
        logic [15:0] sw;
        sw = {h0[7:0], h0[15:8]};
        case (m)
            MODE_WORD:    return {h1, h0};
            MODE_WORD_SW: return {h0, h1};
            MODE_HU_SW:   return {16'h0000, sw};
            MODE_HU:      return {16'h0000, h0};
            MODE_HS_SW:   return {{16{sw[15]}}, sw};
            MODE_HS:      return {{16{h0[15]}}, h0};
            default:      return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (ram_we1) begin
            case (ram_ctrl1)
                MODE_WORD:    begin mem1[ram_addr1] <= ram_din1[15:0];  mem1[nxt1] <= ram_din1[31:16]; end
                MODE_WORD_SW: begin mem1[ram_addr1] <= ram_din1[31:16]; mem1[nxt1] <= ram_din1[15:0];  end
                MODE_HU, MODE_HS:       mem1[ram_addr1] <= ram_din1[15:0];
                MODE_HU_SW, MODE_HS_SW: mem1[ram_addr1] <= {ram_din1[7:0], ram_din1[15:8]};
                default: ;
            endcase
        end
        pipe1 <= rd_fmt(ram_ctrl1, mem1[ram_addr1], mem1[nxt1]);
    end

    always @(posedge clk) begin
        if (ram_we3) begin
            case (ram_ctrl3)
                MODE_WORD:    begin mem3[ram_addr3] <= ram_din3[15:0];  mem3[nxt3] <= ram_din3[31:16]; end
                MODE_WORD_SW: begin mem3[ram_addr3] <= ram_din3[31:16]; mem3[nxt3] <= ram_din3[15:0];  end
                MODE_HU, MODE_HS:       mem3[ram_addr3] <= ram_din3[15:0];
                MODE_HU_SW, MODE_HS_SW: mem3[ram_addr3] <= {ram_din3[7:0], ram_din3[15:8]};
                default: ;
            endcase
        end
        pipe3[0] <= rd_fmt(ram_ctrl3, mem3[ram_addr3], mem3[nxt3]);
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end

    typedef struct {
        logic        ack;
        logic        err;
        logic        busy;
        logic        we;
        logic [31:0] mdr;
        logic [31:0] addr;
        logic [31:0] ctrl;
        logic [31:0] din;
    } obs_t;

    typedef struct {
        string       tag;
        logic        err;
        logic [31:0] mdr;
        int          lat;
        int          we_cycles;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    function automatic obs_t sample(int sel);
        obs_t o;
        if (sel == 1) begin
            o.ack = if1.ack; o.err = if1.err; o.busy = if1.busy; o.we = ram_we1;
            o.mdr = if1.mdr; o.addr = 32'(ram_addr1); o.ctrl = 32'(ram_ctrl1); o.din = ram_din1;
        end else begin
            o.ack = if3.ack; o.err = if3.err; o.busy = if3.busy; o.we = ram_we3;
            o.mdr = if3.mdr; o.addr = 32'(ram_addr3); o.ctrl = 32'(ram_ctrl3); o.din = ram_din3;
        end
        return o;
    endfunction

    task automatic drive(int sel, logic r, logic we, logic [2:0] m, logic [31:0] a, logic [31:0] d);
        if (sel == 1) begin
            if1.req = r; if1.req_we = we; if1.req_mode = m; if1.req_addr = a; if1.req_wdata = d;
        end else begin
            if3.req = r; if3.req_we = we; if3.req_mode = m; if3.req_addr = a; if3.req_wdata = d;
        end
    endtask

    task automatic chk(string tag, string what, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s.%s: observed 0x%08h expected 0x%08h", tag, what, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request from an idle DUT; completion is compared against the scoreboard.
    task automatic txn(int sel, string tag, logic we, logic [2:0] m, logic [31:0] a,
                       logic [31:0] d, logic e_err, logic [31:0] e_mdr, int e_lat);
        exp_t        x;
        obs_t        o;
        int          cyc;
        int          wecnt;
        logic [31:0] addr_issue;
        logic        got;
        sb.push_back('{tag, e_err, e_mdr, e_lat, (we && !e_err) ? 1 : 0});
        drive(sel, 1'b1, we, m, a, d);
        tick();
        drive(sel, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        cyc = 1; wecnt = 0; got = 1'b0;
        o = sample(sel);
        addr_issue = o.addr;
        for (int k = 0; k < 12 && !got; k++) begin
            o = sample(sel);
            if (o.we) wecnt++;
            if (o.ack) got = 1'b1;
            else begin
                tick();
                cyc++;
            end
        end
        x = sb.pop_front();
        chk(x.tag, "ack_seen", 32'(got), 32'd1);
        chk(x.tag, "ack_cycle", 32'(cyc), 32'(x.lat));
        chk(x.tag, "err", 32'(o.err), 32'(x.err));
        chk(x.tag, "mdr", o.mdr, x.mdr);
        chk(x.tag, "we_cycles", 32'(wecnt), 32'(x.we_cycles));
        chk(x.tag, "busy_at_ack", 32'(o.busy), 32'd1);
        if (!e_err) chk(x.tag, "ram_addr", addr_issue, (a >> 1) & 32'h3FF);
        tick();
        o = sample(sel);
        chk(x.tag, "ack_after", 32'(o.ack), 32'd0);
        chk(x.tag, "busy_after", 32'(o.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", passed, total);
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t        o;
        logic [31:0] ackm;
        logic [31:0] busym;

        rst = 1'b1;
        drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive(3, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (3) tick();

        o = sample(1);
        chk("reset", "ack", 32'(o.ack), 32'd0);
        chk("reset", "err", 32'(o.err), 32'd0);
        chk("reset", "busy", 32'(o.busy), 32'd0);
        chk("reset", "ram_we", 32'(o.we), 32'd0);
        chk("reset", "mdr", o.mdr, 32'h0);
        chk("reset", "ram_addr", o.addr, 32'h0);
        chk("reset", "ram_ctrl", o.ctrl, 32'h0);
        chk("reset", "ram_din", o.din, 32'h0);
        rst = 1'b0;
        tick();

        // Word store/load and swapped-word read-back
        txn(1, "st_word",    1'b1, MODE_WORD,    32'h10, 32'hDEADBEEF, 1'b0, 32'h0,        2);
        txn(1, "ld_word",    1'b0, MODE_WORD,    32'h10, 32'h0,        1'b0, 32'hDEADBEEF, 3);
        txn(1, "ld_word_sw", 1'b0, MODE_WORD_SW, 32'h10, 32'h0,        1'b0, 32'hBEEFDEAD, 3);

        // Halfword store, sign/zero-extended and byte-swapped reads
        txn(1, "st_hu",   1'b1, MODE_HU,    32'h22, 32'h00008001, 1'b0, 32'hBEEFDEAD, 2);
        txn(1, "ld_hs",   1'b0, MODE_HS,    32'h22, 32'h0,        1'b0, 32'hFFFF8001, 3);
        txn(1, "ld_hu",   1'b0, MODE_HU,    32'h22, 32'h0,        1'b0, 32'h00008001, 3);
        txn(1, "ld_hu_sw",1'b0, MODE_HU_SW, 32'h22, 32'h0,        1'b0, 32'h00000180, 3);

        // Faults: misaligned store, out of range, illegal modes; mdr must hold
        txn(1, "f_misal",  1'b1, MODE_WORD, 32'h13,  32'h11111111, 1'b1, 32'h00000180, 1);
        txn(1, "f_range",  1'b0, MODE_WORD, 32'h800, 32'h0,        1'b1, 32'h00000180, 1);
        txn(1, "f_mode2",  1'b0, 3'b010,    32'h10,  32'h0,        1'b1, 32'h00000180, 1);
        txn(1, "f_mode3",  1'b1, 3'b011,    32'h10,  32'h22222222, 1'b1, 32'h00000180, 1);

        // Top of the address space
        txn(1, "st_top",    1'b1, MODE_HU,    32'h7FE, 32'h0000C37E, 1'b0, 32'h00000180, 2);
        txn(1, "ld_top_ss", 1'b0, MODE_HS_SW, 32'h7FE, 32'h0,        1'b0, 32'h00007EC3, 3);
        txn(1, "ld_top_hs", 1'b0, MODE_HS,    32'h7FE, 32'h0,        1'b0, 32'hFFFFC37E, 3);

        // req held high through a load: second access starts only after IDLE
        ackm = '0; busym = '0;
        drive(1, 1'b1, 1'b0, MODE_WORD, 32'h10, 32'h0);
        tick();
        for (int c = 1; c <= 8; c++) begin
            o = sample(1);
            if (o.ack)  ackm[c]  = 1'b1;
            if (o.busy) busym[c] = 1'b1;
            if (c == 5) drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
            tick();
        end
        chk("req_busy", "ack_mask", ackm, 32'h88);
        chk("req_busy", "busy_mask", busym, 32'hEE);
        o = sample(1);
        chk("req_busy", "mdr", o.mdr, 32'hDEADBEEF);

        // Reset during ISSUE of a store: ram_we drops, no ack
        drive(1, 1'b1, 1'b1, MODE_WORD, 32'h60, 32'hCAFEF00D);
        tick();
        drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        o = sample(1);
        chk("rst_issue", "ram_we_pre", 32'(o.we), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        o = sample(1);
        chk("rst_issue", "ram_we", 32'(o.we), 32'd0);
        chk("rst_issue", "ack", 32'(o.ack), 32'd0);
        tick();

        // Reset during WAIT of a load: everything cleared, mdr not updated
        drive(1, 1'b1, 1'b0, MODE_WORD, 32'h10, 32'h0);
        tick();
        drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        tick();
        o = sample(1);
        chk("rst_wait", "busy_pre", 32'(o.busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        o = sample(1);
        chk("rst_wait", "ack", 32'(o.ack), 32'd0);
        chk("rst_wait", "err", 32'(o.err), 32'd0);
        chk("rst_wait", "busy", 32'(o.busy), 32'd0);
        chk("rst_wait", "mdr", o.mdr, 32'h0);
        chk("rst_wait", "ram_addr", o.addr, 32'h0);
        tick();
        o = sample(1);
        chk("rst_wait", "ack_late", 32'(o.ack), 32'd0);

        // Longer read latency
        txn(3, "rl3_st", 1'b1, MODE_WORD, 32'h40, 32'h12345678, 1'b0, 32'h0,        2);
        txn(3, "rl3_ld", 1'b0, MODE_WORD, 32'h40, 32'h0,        1'b0, 32'h12345678, 5);
        txn(3, "rl3_hs", 1'b0, MODE_HS,   32'h42, 32'h0,        1'b0, 32'h00001234, 5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
